// File: rtl/car_request_filter.sv
// Road-loop front end: synchronizes and debounces sensor_raw, holds a car request until ack,
// then defers retriggers for a holdoff window. Optional arrival counter under `CAR_COUNT_EN`.
`timescale 1ns/1ps
module car_request_filter #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned HOLDOFF_CYCLES  = 50000000,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sensor_raw,
  input  logic             ack,
  output logic             car,
  output logic             sensor_clean,
  output logic [CNT_W-1:0] car_count
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HO_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HO_W-1:0] HO_LOAD = HO_W'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  logic            sync1_q, sync1_d;
  logic            sync_q, sync_d;
  logic            clean_q, clean_d;
  logic            clean_prev_q, clean_prev_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [HO_W-1:0] ho_cnt_q, ho_cnt_d;
  state_t          state_q, state_d;
  logic            sticky_q, sticky_d;
  logic            car_q, car_d;
  logic            arrival;

  assign arrival = clean_q & ~clean_prev_q;

  // Synchronizer and debounce: sensor_clean follows sync_q only after a full stable window
  always_comb begin
    sync1_d      = sensor_raw;
    sync_d       = sync1_q;
    clean_prev_d = clean_q;
    clean_d      = clean_q;
    db_cnt_d     = '0;
    if (sync_q != clean_q) begin
      if (db_cnt_q == DB_LAST) begin
        clean_d = sync_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  // Request FSM; an arrival in the same cycle as ack is remembered as sticky
  always_comb begin
    state_d  = state_q;
    sticky_d = sticky_q;
    ho_cnt_d = ho_cnt_q;
    case (state_q)
      IDLE: begin
        if (arrival) state_d = PENDING;
      end
      PENDING: begin
        if (ack) begin
          state_d  = HOLDOFF;
          ho_cnt_d = HO_LOAD;
          sticky_d = arrival;
        end
      end
      HOLDOFF: begin
        if (arrival) sticky_d = 1'b1;
        if (ho_cnt_q == '0) begin
          state_d  = (sticky_q || arrival || clean_q) ? PENDING : IDLE;
          sticky_d = 1'b0;
        end else begin
          ho_cnt_d = ho_cnt_q - HO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    car_d = (state_d == PENDING);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync_q       <= 1'b0;
      clean_q      <= 1'b0;
      clean_prev_q <= 1'b0;
      db_cnt_q     <= '0;
      ho_cnt_q     <= '0;
      state_q      <= IDLE;
      sticky_q     <= 1'b0;
      car_q        <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync_q       <= sync_d;
      clean_q      <= clean_d;
      clean_prev_q <= clean_prev_d;
      db_cnt_q     <= db_cnt_d;
      ho_cnt_q     <= ho_cnt_d;
      state_q      <= state_d;
      sticky_q     <= sticky_d;
      car_q        <= car_d;
    end
  end

  assign car          = car_q;
  assign sensor_clean = clean_q;

`ifdef CAR_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating arrival counter
  always_comb begin
    cnt_d = cnt_q;
    if (arrival && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign car_count = cnt_q;
`else
  assign car_count = '0;
`endif

endmodule

// File: tb/tb_car_request_filter.sv
// Directed bench for car_request_filter (DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=8), with a second
// CNT_W=2 instance on the same stimulus for counter saturation.
`timescale 1ns/1ps
module tb_car_request_filter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sensor_raw = 1'b0;
  logic       ack = 1'b0;
  logic       car, sensor_clean;
  logic [7:0] car_count;
  logic       car_s, sensor_clean_s;
  logic [1:0] car_count_s;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  car_request_filter #(.DEBOUNCE_CYCLES(4), .HOLDOFF_CYCLES(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .sensor_raw(sensor_raw), .ack(ack),
    .car(car), .sensor_clean(sensor_clean), .car_count(car_count));

  car_request_filter #(.DEBOUNCE_CYCLES(4), .HOLDOFF_CYCLES(8), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .sensor_raw(sensor_raw), .ack(ack),
    .car(car_s), .sensor_clean(sensor_clean_s), .car_count(car_count_s));

  typedef struct {
    logic raw;
    logic ack;
    int   n;
    logic car;
    logic clean;
    int   arr;
  } vec_t;

  vec_t vecs[29];

  function automatic vec_t mk(logic r, logic a, int n, logic c, logic cl, int arr);
    vec_t v;
    v.raw = r; v.ack = a; v.n = n; v.car = c; v.clean = cl; v.arr = arr;
    return v;
  endfunction

  function automatic int exp_cnt(int arr, int maxv);
`ifdef CAR_COUNT_EN
    return (arr > maxv) ? maxv : arr;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  initial begin
    // glitch rejection: raw high 3 cycles
    vecs[0]  = mk(1, 0, 3,  0, 0, 0);
    vecs[1]  = mk(0, 0, 6,  0, 0, 0);
    // clean arrival: clean at edge 6, car at edge 7, held without ack
    vecs[2]  = mk(1, 0, 5,  0, 0, 0);
    vecs[3]  = mk(1, 0, 1,  0, 1, 0);
    vecs[4]  = mk(1, 0, 1,  1, 1, 1);
    vecs[5]  = mk(1, 0, 20, 1, 1, 1);
    // ack with raw dropped, 8-cycle holdoff, back to idle
    vecs[6]  = mk(0, 1, 1,  0, 1, 1);
    vecs[7]  = mk(0, 0, 4,  0, 1, 1);
    vecs[8]  = mk(0, 0, 1,  0, 0, 1);
    vecs[9]  = mk(0, 0, 3,  0, 0, 1);
    // new request, then arrival 3 cycles into holdoff is deferred
    vecs[10] = mk(1, 0, 7,  1, 1, 2);
    vecs[11] = mk(0, 0, 10, 1, 0, 2);
    vecs[12] = mk(1, 0, 3,  1, 0, 2);
    vecs[13] = mk(1, 1, 1,  0, 0, 2);
    vecs[14] = mk(1, 0, 2,  0, 1, 2);
    vecs[15] = mk(1, 0, 1,  0, 1, 3);
    vecs[16] = mk(1, 0, 4,  0, 1, 3);
    vecs[17] = mk(1, 0, 1,  1, 1, 3);
    // arrival and ack together: sticky alone re-raises car after holdoff
    vecs[18] = mk(0, 0, 8,  1, 0, 3);
    vecs[19] = mk(1, 0, 6,  1, 1, 3);
    vecs[20] = mk(0, 1, 1,  0, 1, 4);
    vecs[21] = mk(0, 0, 7,  0, 0, 4);
    vecs[22] = mk(0, 0, 1,  1, 0, 4);
    // plain ack to idle, then ack in idle is ignored
    vecs[23] = mk(0, 1, 1,  0, 0, 4);
    vecs[24] = mk(0, 0, 8,  0, 0, 4);
    vecs[25] = mk(0, 1, 1,  0, 0, 4);
    vecs[26] = mk(0, 0, 3,  0, 0, 4);
    // fifth arrival: narrow counter saturates
    vecs[27] = mk(1, 0, 6,  0, 1, 4);
    vecs[28] = mk(1, 0, 1,  1, 1, 5);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_car", 0, int'(car), 0);
    check("reset_clean", 0, int'(sensor_clean), 0);
    check("reset_count", 0, int'(car_count), 0);
    check("reset_count_sat", 0, int'(car_count_s), 0);
    reset = 1'b0;

    for (int i = 0; i < 29; i++) begin
      sensor_raw = vecs[i].raw;
      ack        = vecs[i].ack;
      repeat (vecs[i].n) @(posedge clk);
      @(negedge clk);
      check("car", i, int'(car), int'(vecs[i].car));
      check("sensor_clean", i, int'(sensor_clean), int'(vecs[i].clean));
      check("car_count", i, int'(car_count), exp_cnt(vecs[i].arr, 255));
      check("car_count_sat", i, int'(car_count_s), exp_cnt(vecs[i].arr, 3));
    end
    ack = 1'b0;

    // asynchronous reset while PENDING: outputs clear before any clock edge
    #2 reset = 1'b1;
    #1;
    check("async_rst_car", 0, int'(car), 0);
    check("async_rst_clean", 0, int'(sensor_clean), 0);
    check("async_rst_count", 0, int'(car_count), 0);
    check("async_rst_count_sat", 0, int'(car_count_s), 0);
    sensor_raw = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("post_rst_car", 0, int'(car), 0);
    check("post_rst_clean", 0, int'(sensor_clean), 0);
    check("post_rst_count", 0, int'(car_count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
